// File: rtl/regs_scoreboard_if.sv
// rtl/regs_scoreboard_if.sv - decode issue and writeback handshake bundle for the register scoreboard
interface regs_scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rs1;
  logic [4:0] issue_rs2;
  logic       issue_use_rs1;
  logic       issue_use_rs2;
  logic       issue_wr;
  logic [4:0] issue_rd;
  logic       issue_ready;
  logic       wb_valid;
  logic [4:0] wb_addr;
  logic       flush;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    output issue_wr, issue_rd, wb_valid, wb_addr, flush,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    input  issue_wr, issue_rd, wb_valid, wb_addr, flush,
    output issue_ready
  );
endinterface

// File: rtl/regs_scoreboard.sv
// rtl/regs_scoreboard.sv - per-register in-flight write tracker gating decode issue
module regs_scoreboard #(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  regs_scoreboard_if.slave  bus,
  output logic [31:0]       busy_mask,
  output logic              underflow_err,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] pending [32];
  logic [CNT_W-1:0] eff     [32];
  logic [CNT_W-1:0] nxt     [32];
  logic [31:0]      dec;
  logic [31:0]      inc;
  logic             raw1;
  logic             raw2;
  logic             full;
  logic             fire;
  logic             wb_under;

  // Writeback retires this cycle; the register file commits on the falling
  // edge, so readers already see the value and the decremented count applies.
  always_comb begin
    dec = '0;
    for (int r = 0; r < 32; r++) begin
      dec[r] = bus.wb_valid && (bus.wb_addr == 5'(r)) && (r != 0) && (pending[r] != '0);
      eff[r] = dec[r] ? (pending[r] - CNT_ONE) : pending[r];
    end
  end

  // Hazard detection and issue handshake; independent of issue_valid.
  always_comb begin
    raw1 = bus.issue_use_rs1 && (bus.issue_rs1 != 5'd0) && (eff[bus.issue_rs1] != '0);
    raw2 = bus.issue_use_rs2 && (bus.issue_rs2 != 5'd0) && (eff[bus.issue_rs2] != '0);
    full = bus.issue_wr && (bus.issue_rd != 5'd0) && (eff[bus.issue_rd] == CNT_MAX);
    bus.issue_ready = !bus.flush && !raw1 && !raw2 && !full;
    fire = bus.issue_valid && bus.issue_ready;
  end

  // Next pending count: issue increments, writeback decrements, both cancel.
  always_comb begin
    inc = '0;
    for (int r = 0; r < 32; r++) begin
      inc[r] = fire && bus.issue_wr && (bus.issue_rd == 5'(r)) && (r != 0);
      nxt[r] = pending[r];
      if (inc[r] && !dec[r]) begin
        nxt[r] = pending[r] + CNT_ONE;
      end else if (!inc[r] && dec[r]) begin
        nxt[r] = pending[r] - CNT_ONE;
      end
    end
  end

  // Retiring an address that has nothing outstanding; flushed writebacks are ignored.
  always_comb begin
    wb_under = bus.wb_valid && (bus.wb_addr != 5'd0) && (pending[bus.wb_addr] == '0) && !bus.flush;
  end

  // Pending counters; flush drops every outstanding write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        pending[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        pending[r] <= bus.flush ? '0 : nxt[r];
      end
    end
  end

  // Busy view of the registered counters, x0 never busy.
  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < 32; r++) begin
      busy_mask[r] = (pending[r] != '0);
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_err <= 1'b0;
    end else if (wb_under) begin
      underflow_err <= 1'b1;
    end
  end

  // Saturating count of cycles where decode was held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (bus.issue_valid && !bus.issue_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_regs_scoreboard.sv
// tb/tb_regs_scoreboard.sv - scoreboard-checked directed vectors for regs_scoreboard
module tb_regs_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] busy_mask;
  logic        underflow_err;
  logic [31:0] stall_cycles;

  regs_scoreboard_if sb_if ();

  regs_scoreboard #(.CNT_W(2), .PERF_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (sb_if),
    .busy_mask     (busy_mask),
    .underflow_err (underflow_err),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rdy;
    logic [31:0] busy;
    logic        uf;
    logic [31:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor: compares the DUT against the oldest expectation every falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp({e.nm, ".ready"}, {31'd0, sb_if.issue_ready}, {31'd0, e.rdy});
      cmp({e.nm, ".busy"},  busy_mask, e.busy);
      cmp({e.nm, ".uf"},    {31'd0, underflow_err}, {31'd0, e.uf});
      cmp({e.nm, ".stall"}, stall_cycles, e.stall);
    end
  end

  task automatic drive(input bit v, input bit u1, input logic [4:0] r1, input bit u2,
                       input logic [4:0] r2, input bit wr, input logic [4:0] rd,
                       input bit wbv, input logic [4:0] wba, input bit fl);
    sb_if.issue_valid   = v;
    sb_if.issue_use_rs1 = u1;
    sb_if.issue_rs1     = r1;
    sb_if.issue_use_rs2 = u2;
    sb_if.issue_rs2     = r2;
    sb_if.issue_wr      = wr;
    sb_if.issue_rd      = rd;
    sb_if.wb_valid      = wbv;
    sb_if.wb_addr       = wba;
    sb_if.flush         = fl;
  endtask

  // One cycle: drive after the rising edge, queue what must be seen this cycle.
  task automatic step(input string nm, input bit v, input bit u1, input logic [4:0] r1,
                      input bit u2, input logic [4:0] r2, input bit wr, input logic [4:0] rd,
                      input bit wbv, input logic [4:0] wba, input bit fl,
                      input bit er, input logic [31:0] eb, input bit eu, input logic [31:0] es);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v, u1, r1, u2, r2, wr, rd, wbv, wba, fl);
    e.nm = nm; e.rdy = er; e.busy = eb; e.uf = eu; e.stall = es;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //     name        v u1 r1 u2 r2 wr rd wbv wba fl  rdy busy       uf stall
    step("reset",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h0,      0, 0);
    @(posedge clk); #1 rst = 1'b0;
    step("iss_rd5",    1, 0, 0, 0, 0, 1, 5, 0, 0, 0,   1, 32'h0,      0, 0);
    step("raw_rs1_5",  1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   0, 32'h20,     0, 0);
    step("idle_a",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h20,     0, 1);
    step("byp_rs2_5",  1, 0, 0, 1, 5, 0, 0, 1, 5, 0,   1, 32'h20,     0, 1);
    step("x5_clear",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h0,      0, 1);
    step("iss_rd5_b",  1, 0, 0, 0, 0, 1, 5, 0, 0, 0,   1, 32'h0,      0, 1);
    step("inc_dec_x5", 1, 1, 5, 0, 0, 1, 5, 1, 5, 0,   1, 32'h20,     0, 1);
    step("x5_held",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h20,     0, 1);
    step("wb_x5",      0, 0, 0, 0, 0, 0, 0, 1, 5, 0,   1, 32'h20,     0, 1);
    step("x5_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h0,      0, 1);
    step("rd7_1",      1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   1, 32'h0,      0, 1);
    step("rd7_2",      1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   1, 32'h80,     0, 1);
    step("rd7_3",      1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   1, 32'h80,     0, 1);
    step("rd7_full",   1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   0, 32'h80,     0, 1);
    step("rd7_full_wb",1, 0, 0, 0, 0, 1, 7, 1, 7, 0,   1, 32'h80,     0, 2);
    step("rd7_still3", 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   0, 32'h80,     0, 2);
    step("wb7_a",      0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   1, 32'h80,     0, 3);
    step("wb7_b",      0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   1, 32'h80,     0, 3);
    step("wb7_c",      0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   1, 32'h80,     0, 3);
    step("x7_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h0,      0, 3);
    step("x0_a",       1, 1, 0, 1, 0, 1, 0, 0, 0, 0,   1, 32'h0,      0, 3);
    step("x0_b",       1, 1, 0, 1, 0, 1, 0, 0, 0, 0,   1, 32'h0,      0, 3);
    step("x0_wb0",     1, 1, 0, 1, 0, 1, 0, 1, 0, 0,   1, 32'h0,      0, 3);
    step("wb9_idle",   0, 0, 0, 0, 0, 0, 0, 1, 9, 0,   1, 32'h0,      0, 3);
    step("uf_set",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h0,      1, 3);
    step("uf_sticky",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h0,      1, 3);
    step("iss_rd3",    1, 0, 0, 0, 0, 1, 3, 0, 0, 0,   1, 32'h0,      1, 3);
    step("iss_rd4",    1, 0, 0, 0, 0, 1, 4, 0, 0, 0,   1, 32'h08,     1, 3);
    step("flush",      1, 1, 9, 0, 0, 0, 0, 1, 3, 1,   0, 32'h18,     1, 3);
    step("post_flush", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0,   1, 32'h0,      1, 4);
    step("iss_rd6",    1, 0, 0, 0, 0, 1, 6, 0, 0, 0,   1, 32'h0,      1, 4);
    step("x6_busy",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 32'h40,     1, 4);

    // Asynchronous reset between clock edges: state must clear before the next edge.
    @(posedge clk);
    #1;
    drive(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    e.nm = "async_rst"; e.rdy = 1'b1; e.busy = 32'h0; e.uf = 1'b0; e.stall = 32'h0;
    exp_q.push_back(e);
    @(posedge clk); #1 rst = 1'b0;
    step("after_rst",  1, 1, 6, 0, 0, 0, 0, 0, 0, 0,   1, 32'h0,      0, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_scoreboard.md
Name: regs_scoreboard

Overview:
- Read-side companion to the register file: the decode stage uses it to decide whether source operands read from the file are valid.
- Tracks in-flight writes per architectural register (x1–x31) and issues a ready/stall handshake to decode.
- Issue marks the destination pending; writeback (the register-file write enable and address) retires it.
- Register file commits on the falling edge, so a writeback in cycle N is readable in the same cycle N. The scoreboard treats a same-cycle writeback as already resolved.

Parameters:
- CNT_W, 2: width of per-register pending counter (max in-flight writes to one rd = 2^CNT_W−1).
- PERF_W, 32: width of stall-cycle performance counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- issue_valid  input  1  decode presents an instruction
- issue_rs1  input  5  source register 1 address
- issue_rs2  input  5  source register 2 address
- issue_use_rs1  input  1  instruction reads rs1
- issue_use_rs2  input  1  instruction reads rs2
- issue_wr  input  1  instruction will write rd
- issue_rd  input  5  destination register address
- issue_ready  output  1  combinational; instruction may issue this cycle
- wb_valid  input  1  writeback enable (same signal as the register-file write enable)
- wb_addr  input  5  writeback destination address
- flush  input  1  synchronous clear of all pending state (pipeline flush)
- busy_mask  output  32  bit r = 1 when pending[r] != 0; bit 0 always 0
- underflow_err  output  1  sticky: writeback retired a register with no pending write
- stall_cycles  output  PERF_W  count of cycles with issue_valid && !issue_ready

Behaviour:
- Reset (async, rst=1):
  - All pending counters are 0; underflow_err=0; stall_cycles=0; busy_mask=0.
  - issue_ready evaluates to 1 unless flush=1.
- Register 0:
  - Never pending.
  - Issue with rd=0 or wb_addr=0 has no effect.
  - rs=0 never causes a hazard.
- Per-cycle decrement term:
  - dec[r] = wb_valid && wb_addr==r && r!=0 && pending[r]!=0.
  - eff[r] = pending[r] − dec[r].
- Hazard terms:
  - raw1 = issue_use_rs1 && issue_rs1!=0 && eff[issue_rs1]!=0; raw2 is the same for rs2.
  - full = issue_wr && issue_rd!=0 && eff[issue_rd]==2^CNT_W−1.
- issue_ready = !flush && !raw1 && !raw2 && !full. This is purely combinational, with no dependence on issue_valid.
- fire = issue_valid && issue_ready.
- Counter update each rising edge:
  - pending[r] <= pending[r] + (fire && issue_wr && issue_rd==r && r!=0) − dec[r].
  - Simultaneous increment and decrement of the same register leaves it unchanged.
- WAW: multiple writes to the same rd are allowed up to the counter maximum. rd stays busy until all are retired.
- Writeback to a register with pending==0 (non-zero addr): counter unchanged; underflow_err <= 1, held until rst.
- flush=1:
  - Next edge, all counters go to 0 and the writeback in that cycle is ignored.
  - issue_ready=0 during the flush cycle; stall_cycles still counts it if issue_valid=1.
  - underflow_err and stall_cycles are not cleared by flush.
- stall_cycles increments when issue_valid && !issue_ready, saturating at all-ones; it does not wrap.
- busy_mask is registered state (derived from counters), not including same-cycle decrement.
- Reset mid-operation clears everything immediately, regardless of clock.

Test Plan:
- Reset then issue rd=5 (valid, wr=1); next cycle issue rs1=5 with no wb → issue_ready=0, busy_mask=0x20, stall_cycles increments to 1.
- Pending x5, and in the same cycle wb_valid=1, wb_addr=5 and issue rs2=5 → issue_ready=1 (same-cycle bypass); x5 counter back to 0 after the edge only if no new write to x5 is issued.
- Issue rd=7 three times (CNT_W=2) → pending[7]=3; fourth issue with rd=7 → issue_ready=0 (full). With wb_addr=7 in that cycle → ready=1 and pending stays 3.
- Issue rd=0 and rs1=0 repeatedly → issue_ready always 1, busy_mask stays 0; wb_valid with wb_addr=9 while x9 is idle → underflow_err=1 and sticky.
- Pending x3 and x4, assert flush with issue_valid=1 → issue_ready=0 that cycle; next cycle busy_mask=0 and issue of rs1=3 is ready. Assert rst asynchronously mid-cycle → all outputs cleared immediately.
